mii_tx_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 21 ++
 rtl/eth_crc32.sv | 17 +
 rtl/mii_tx_framer.sv | 212 +++++++++++++++++++++
 tb/tb_mii_tx_framer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: transmit FSM states, MII nibble codes, CRC-32 constants.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_e;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  // Register value left after running the CRC over a frame plus its own FCS.
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32.sv
// Byte-wise reflected CRC-32 step (combinational), shared by TX framing and RX FCS check.
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // LSB-first shift of eight data bits through the reflected polynomial
  always_comb begin
    crc_o = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++)
      crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC_POLY) : (crc_o >> 1);
  end

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble/SFD, payload nibbles, zero pad, FCS, inter-frame gap.
module mii_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME        = 60,
  parameter int IFG_NIBBLES      = 24,
  parameter int PREAMBLE_NIBBLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       eth_tx_en,
  output logic [3:0] eth_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int NIB_MAX = (PREAMBLE_NIBBLES > IFG_NIBBLES) ? PREAMBLE_NIBBLES : IFG_NIBBLES;
  localparam int NW_RAW  = $clog2(NIB_MAX + 1);
  // The FCS phase also walks this counter through 8 nibbles.
  localparam int NW      = (NW_RAW < 3) ? 3 : NW_RAW;
  localparam logic [11:0] MIN_F = 12'(MIN_FRAME);

  tx_state_e       state_q, state_d;
  logic [NW-1:0]   nib_q, nib_d;
  logic            phase_q, phase_d;
  logic [7:0]      byte_q, byte_d;
  logic            last_q, last_d;
  logic [10:0]     cnt_q, cnt_d;
  logic [31:0]     crc_q, crc_d;

  logic [3:0]      txd_q, txd_d;
  logic            tx_en_q, tx_en_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            urun_q, urun_d;

  logic [7:0]      crc_byte;
  logic [31:0]     crc_nxt;
  logic [31:0]     fcs_w;
  logic [10:0]     cnt_inc;
  logic            pad_needed;

  assign crc_byte   = (state_q == PAD) ? 8'h00 : byte_q;
  assign fcs_w      = ~crc_d;
  assign cnt_inc    = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  // Byte count after the byte finishing this cycle is still short of the minimum.
  assign pad_needed = ({1'b0, cnt_q} + 12'd1) < MIN_F;

  eth_crc32 u_crc (
    .crc_i  (crc_q),
    .data_i (crc_byte),
    .crc_o  (crc_nxt)
  );

  // State, datapath and registered outputs; reset drops tx_en immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      nib_q   <= '0;
      phase_q <= 1'b0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      txd_q   <= '0;
      tx_en_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      phase_q <= phase_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

  // Next state: nibble sequencing, byte latch, CRC/count update on each byte's high nibble
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    phase_d = phase_q;
    byte_d  = byte_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    urun_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid && ready_q) begin
          byte_d  = s_data;
          last_d  = s_last;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
          nib_d   = '0;
          phase_d = 1'b0;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (nib_q == NW'(PREAMBLE_NIBBLES - 1)) begin
          nib_d   = '0;
          state_d = SFD;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      SFD: begin
        phase_d = 1'b0;
        state_d = DATA;
      end
      DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          crc_d   = crc_nxt;
          cnt_d   = cnt_inc;
          nib_d   = '0;
          if (last_q) begin
            state_d = pad_needed ? PAD : FCS;
          end else if (s_valid) begin
            byte_d = s_data;
            last_d = s_last;
          end else begin
            // Starved mid-frame: abandon without FCS so the receiver drops it.
            urun_d  = 1'b1;
            state_d = IFG;
          end
        end
      end
      PAD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          crc_d   = crc_nxt;
          cnt_d   = cnt_inc;
          nib_d   = '0;
          if (!pad_needed) state_d = FCS;
        end
      end
      FCS: begin
        if (nib_q == NW'(7)) begin
          nib_d   = '0;
          state_d = IFG;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      IFG: begin
        if (nib_q == NW'(IFG_NIBBLES - 1)) begin
          nib_d   = '0;
          state_d = IDLE;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs for the coming cycle, derived from the next state so they register cleanly
  always_comb begin
    txd_d   = '0;
    tx_en_d = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    case (state_d)
      IDLE:     ready_d = 1'b1;
      PREAMBLE: begin tx_en_d = 1'b1; txd_d = PREAMBLE_NIB; end
      SFD:      begin tx_en_d = 1'b1; txd_d = SFD_NIB; end
      DATA: begin
        tx_en_d = 1'b1;
        txd_d   = phase_d ? byte_d[7:4] : byte_d[3:0];
        ready_d = phase_d && !last_d;
      end
      PAD:      tx_en_d = 1'b1;
      FCS: begin
        tx_en_d = 1'b1;
        txd_d   = fcs_w[{nib_d[2:0], 2'b00} +: 4];
      end
      IFG:      done_d = (nib_d == NW'(IFG_NIBBLES - 1));
      default:  ;
    endcase
  end

  assign s_ready    = ready_q;
  assign eth_tx_en  = tx_en_q;
  assign eth_txd    = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = urun_q;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench: instance 0 has padding disabled (CRC check value), instance 1 uses defaults.
module tb_mii_tx_framer;
  import eth_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data [2];
  logic [3:0] txd [2];
  logic [1:0] s_valid, s_last, s_ready, en, busy, fd, ur;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [3:0] cap [2][$];
  logic [3:0] last_frame [2][$];
  int fall_cyc [2];
  int gap [2];
  int done_gap [2];
  int done_cnt [2];
  int ur_cnt [2];
  logic [7:0] pay_q [$];
  logic [7:0] ref_q [$];

  always #20 clk = ~clk;

  mii_tx_framer #(.MIN_FRAME(0), .IFG_NIBBLES(24), .PREAMBLE_NIBBLES(15)) u_np (
    .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_ready(s_ready[0]), .eth_tx_en(en[0]), .eth_txd(txd[0]), .busy(busy[0]),
    .frame_done(fd[0]), .underrun(ur[0])
  );

  mii_tx_framer #(.MIN_FRAME(60), .IFG_NIBBLES(24), .PREAMBLE_NIBBLES(15)) u_dut (
    .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_ready(s_ready[1]), .eth_tx_en(en[1]), .eth_txd(txd[1]), .busy(busy[1]),
    .frame_done(fd[1]), .underrun(ur[1])
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: capture nibbles per tx_en burst, track gaps and pulses
  initial begin
    logic [1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (en[k] === 1'b1) cap[k].push_back(txd[k]);
        if (prev[k] && en[k] !== 1'b1) begin
          last_frame[k] = cap[k];
          cap[k].delete();
          fall_cyc[k] = cyc;
        end
        if (!prev[k] && en[k] === 1'b1) gap[k] = cyc - fall_cyc[k];
        if (ur[k] === 1'b1) ur_cnt[k]++;
        if (fd[k] === 1'b1) begin
          done_cnt[k]++;
          done_gap[k] = cyc - fall_cyc[k] + 1;
        end
        prev[k] = (en[k] === 1'b1);
      end
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] get_fcs(input int k, input int off);
    logic [31:0] f;
    f = '0;
    for (int j = 0; j < 8; j++) f[4*j +: 4] = last_frame[k][off + j];
    return f;
  endfunction

  task automatic send(input int k, input int off, input int n, input bit with_last);
    int i;
    int g;
    i = 0;
    g = 0;
    while (i < n && g < 4000) begin
      @(negedge clk);
      s_valid[k] = 1'b1;
      s_data[k]  = pay_q[off + i];
      s_last[k]  = with_last && (i == n - 1);
      if (s_ready[k] === 1'b1) i++;
      g++;
    end
    if (i < n) chk("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
  endtask

  task automatic wait_done(input int k, input int tgt);
    int g;
    g = 0;
    while (done_cnt[k] < tgt && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("done_wait", 32'(done_cnt[k]), 32'(tgt));
  endtask

  task automatic check_frame(input int k, input string tag, input bit fcs_on);
    int bad;
    int nb;
    logic [7:0] b;
    logic [31:0] c;
    logic [31:0] f;
    nb = ref_q.size();
    chk({tag, "_len"}, 32'(last_frame[k].size()), 32'(16 + 2 * nb + (fcs_on ? 8 : 0)));
    bad = 0;
    for (int i = 0; i < 15; i++) if (last_frame[k][i] !== PREAMBLE_NIB) bad++;
    if (last_frame[k][15] !== SFD_NIB) bad++;
    chk({tag, "_pre"}, 32'(bad), 0);
    bad = 0;
    c = CRC_INIT;
    for (int i = 0; i < nb; i++) begin
      b = {last_frame[k][17 + 2 * i], last_frame[k][16 + 2 * i]};
      if (b !== ref_q[i]) bad++;
      c = crc_upd(c, ref_q[i]);
    end
    chk({tag, "_data"}, 32'(bad), 0);
    if (fcs_on) begin
      f = get_fcs(k, 16 + 2 * nb);
      chk({tag, "_fcs"}, f, ~c);
      for (int j = 0; j < 4; j++) c = crc_upd(c, f[8*j +: 8]);
      chk({tag, "_res"}, c, CRC_RESIDUE);
    end
  endtask

  task automatic build_ref(input int off, input int n, input int min_len);
    ref_q.delete();
    for (int i = 0; i < n; i++) ref_q.push_back(pay_q[off + i]);
    while (ref_q.size() < min_len) ref_q.push_back(8'h00);
  endtask

  initial begin
    s_valid = '0;
    s_last  = '0;
    s_data[0] = '0;
    s_data[1] = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_en",   32'(en), 0);
    chk("rst_txd",  32'({txd[1], txd[0]}), 0);
    chk("rst_rdy",  32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fd",   32'(fd), 0);
    chk("rst_ur",   32'(ur), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_rdy", 32'(s_ready), 32'h3);

    // CRC check value "123456789", no padding
    pay_q.delete();
    for (int i = 0; i < 9; i++) pay_q.push_back(8'(8'h31 + i));
    build_ref(0, 9, 0);
    send(0, 0, 9, 1);
    idle(0);
    wait_done(0, 1);
    check_frame(0, "crc", 1);
    chk("crc_chk", get_fcs(0, 34), 32'hCBF43926);
    chk("crc_ifg", 32'(done_gap[0]), 24);
    @(negedge clk);
    chk("crc_rdy", 32'(s_ready[0]), 1);

    // 14-byte payload padded to 60
    pay_q.delete();
    for (int i = 0; i < 14; i++) pay_q.push_back(8'(i * 29 + 7));
    build_ref(0, 14, 60);
    send(1, 0, 14, 1);
    idle(1);
    wait_done(1, 1);
    check_frame(1, "pad", 1);
    chk("pad_ifg", 32'(done_gap[1]), 24);

    // 64 random bytes, no pad: 16+128+8 tx_en cycles
    pay_q.delete();
    for (int i = 0; i < 64; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    build_ref(0, 64, 0);
    send(1, 0, 64, 1);
    idle(1);
    wait_done(1, 2);
    check_frame(1, "nopad", 1);

    // underrun after 20 bytes
    pay_q.delete();
    for (int i = 0; i < 20; i++) pay_q.push_back(8'(i * 7 + 100));
    build_ref(0, 20, 0);
    send(1, 0, 20, 0);
    idle(1);
    wait_done(1, 3);
    chk("urun_cnt", 32'(ur_cnt[1]), 1);
    check_frame(1, "urun", 0);
    chk("urun_ifg", 32'(done_gap[1]), 24);
    @(negedge clk);
    chk("urun_rdy",  32'(s_ready[1]), 1);
    chk("urun_busy", 32'(busy[1]), 0);

    // back-to-back frames with s_valid held high
    pay_q.delete();
    for (int i = 0; i < 80; i++) pay_q.push_back(8'(i * 13 + 5));
    send(1, 0, 10, 1);
    send(1, 10, 70, 1);
    idle(1);
    build_ref(0, 10, 60);
    check_frame(1, "b2b1", 1);
    chk("b2b_gap", {31'b0, gap[1] >= 24}, 1);
    wait_done(1, 5);
    build_ref(10, 70, 0);
    check_frame(1, "b2b2", 1);

    // reset in the middle of DATA, then a clean frame
    pay_q.delete();
    for (int i = 0; i < 30; i++) pay_q.push_back(8'(i * 53 + 1));
    send(1, 0, 8, 0);
    @(posedge clk);
    #5;
    chk("rst_pre_en", 32'(en[1]), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_en",   32'(en[1]), 0);
    chk("rst_mid_busy", 32'(busy[1]), 0);
    chk("rst_mid_rdy",  32'(s_ready[1]), 0);
    s_valid[1] = 1'b0;
    s_last[1]  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_rdy", 32'(s_ready[1]), 1);
    build_ref(0, 14, 60);
    send(1, 0, 14, 1);
    idle(1);
    wait_done(1, 6);
    check_frame(1, "post_rst", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
